alu8_seq: RTL

- Command sequencer and accumulator stage that drives the alu8 operand and opcode inputs, then captures its res/flg outputs.
- Holds a 16-bit accumulator and a 4-bit flag register.
- Executes 8-bit ops in one ALU pass and 16-bit ops in two passes, chaining the carry between them.
- Sits between the command source (valid/ready) and the external 8-bit ALU instance.

---
 rtl/alu8_seq.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/alu8_seq.sv
// Command sequencer and 16-bit accumulator around an external 8-bit ALU.
// Narrow ops take one ALU pass, wide ops take two with the carry chained from low to high byte.
module alu8_seq (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [3:0]  cmd_op,
   input  logic        cmd_wide,
   input  logic        cmd_ld,
   input  logic [15:0] cmd_b,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_op,
   input  logic [7:0]  alu_res,
   input  logic [3:0]  alu_flg,
   output logic [15:0] acc,
   output logic [3:0]  flg,
   output logic        done
);

   localparam int unsigned BYTE_W = 8;
   localparam int unsigned ACC_W  = 16;
   localparam int unsigned OP_W   = 4;
   localparam int unsigned FLG_W  = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LO   = 2'd1,
      HI   = 2'd2
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [ACC_W-1:0]    r_acc, w_acc_nxt;
   logic [FLG_W-1:0]    r_flg, w_flg_nxt;
   logic                r_done, w_done_nxt;
   logic                r_ready, w_ready_nxt;
   logic [ACC_W-1:0]    r_b, w_b_nxt;
   logic [OP_W-1:0]     r_op, w_op_nxt;
   logic                r_wide, w_wide_nxt;
   logic                r_z_lo, w_z_lo_nxt;
   logic [BYTE_W-1:0]   r_alu_a, w_alu_a_nxt;
   logic [BYTE_W-1:0]   r_alu_b, w_alu_b_nxt;
   logic [OP_W-1:0]     r_alu_op, w_alu_op_nxt;
   logic                w_accept;

   assign w_accept = cmd_valid & r_ready;

   // State and datapath registers; reset aborts any command in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= IDLE;
         r_acc    <= '0;
         r_flg    <= '0;
         r_done   <= 1'b0;
         r_ready  <= 1'b1;
         r_b      <= '0;
         r_op     <= '0;
         r_wide   <= 1'b0;
         r_z_lo   <= 1'b0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_alu_op <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_acc    <= w_acc_nxt;
         r_flg    <= w_flg_nxt;
         r_done   <= w_done_nxt;
         r_ready  <= w_ready_nxt;
         r_b      <= w_b_nxt;
         r_op     <= w_op_nxt;
         r_wide   <= w_wide_nxt;
         r_z_lo   <= w_z_lo_nxt;
         r_alu_a  <= w_alu_a_nxt;
         r_alu_b  <= w_alu_b_nxt;
         r_alu_op <= w_alu_op_nxt;
      end
   end

   // Next-state and next-output logic; ALU drive registers fall back to zero in IDLE.
   always_comb begin
      w_state_nxt  = r_state;
      w_acc_nxt    = r_acc;
      w_flg_nxt    = r_flg;
      w_done_nxt   = 1'b0;
      w_b_nxt      = r_b;
      w_op_nxt     = r_op;
      w_wide_nxt   = r_wide;
      w_z_lo_nxt   = r_z_lo;
      w_alu_a_nxt  = '0;
      w_alu_b_nxt  = '0;
      w_alu_op_nxt = '0;

      case (r_state)
         IDLE: begin
            if (w_accept) begin
               if (cmd_ld) begin
                  w_acc_nxt  = cmd_b;
                  w_done_nxt = 1'b1;
               end else begin
                  w_b_nxt      = cmd_b;
                  w_op_nxt     = cmd_op;
                  w_wide_nxt   = cmd_wide;
                  w_alu_a_nxt  = r_acc[BYTE_W-1:0];
                  w_alu_b_nxt  = cmd_b[BYTE_W-1:0];
                  w_alu_op_nxt = cmd_op;
                  w_state_nxt  = LO;
               end
            end
         end

         LO: begin
            w_acc_nxt[BYTE_W-1:0] = alu_res;
            w_z_lo_nxt            = alu_flg[2];
            if (r_wide) begin
               // Low-byte carry-out is folded straight into the registered high-pass opcode.
               w_alu_a_nxt  = r_acc[ACC_W-1:BYTE_W];
               w_alu_b_nxt  = r_b[ACC_W-1:BYTE_W];
               w_alu_op_nxt = {r_op[3:1], (r_op[3] ? alu_flg[3] : r_op[0])};
               w_state_nxt  = HI;
            end else begin
               w_flg_nxt   = alu_flg;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end
         end

         HI: begin
            w_acc_nxt[ACC_W-1:BYTE_W] = alu_res;
            w_flg_nxt   = {alu_flg[3], r_z_lo & alu_flg[2], alu_flg[1], alu_flg[0]};
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase

      w_ready_nxt = (w_state_nxt == IDLE);
   end

   assign cmd_ready = r_ready;
   assign alu_a     = r_alu_a;
   assign alu_b     = r_alu_b;
   assign alu_op    = r_alu_op;
   assign acc       = r_acc;
   assign flg       = r_flg;
   assign done      = r_done;

endmodule
